// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Start/busy/done handshake; flags invalid digits and results that do not fit in BIN_W.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  overflow,
    output logic                  err
);

    localparam int   W       = 4 * DIGITS;
    localparam int   CNT_W   = $clog2(W + 1);
    localparam logic HAS_OVF = (BIN_W < W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       bcd_q, bcd_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*W-1:0]     shift_s;
    logic [W-1:0]       acc_hi_s;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // After the right shift, a digit of 8 or more received a borrowed 10 weighted as 16.
    function automatic logic [W-1:0] correct_digits(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            r[4*i +: 4] = (d >= 4'd8) ? (d - 4'd3) : d;
        end
        return r;
    endfunction

    // Next-state, datapath and output-register computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        shift_s  = {bcd_q, acc_q} >> 1'b1;
        acc_hi_s = {W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (has_bad_digit(bcd_in)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        bin_d   = {BIN_W{1'b0}};
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        bcd_d   = bcd_in;
                        acc_d   = {W{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = shift_s[W-1:0];
                bcd_d = correct_digits(shift_s[2*W-1:W]);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d  = ST_DONE;
                    acc_hi_s = acc_d >> BIN_W;
                    bin_d    = BIN_W'(acc_d);
                    ovf_d    = HAS_OVF & (|acc_hi_s);
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bcd_q   <= {W{1'b0}};
            acc_q   <= {W{1'b0}};
            bin_q   <= {BIN_W{1'b0}};
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bin_out  = bin_q;
    assign overflow = ovf_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq: latency, values, flags, ignored starts,
// reset abort and back-to-back timing, all against hand-computed constants.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy, done, overflow, err;
    logic [7:0]  bin_out;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bcd_in   (bcd_in),
        .busy     (busy),
        .done     (done),
        .bin_out  (bin_out),
        .overflow (overflow),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one request and wait (bounded) for done; lat counts edges after the accept edge.
    task automatic convert(input logic [11:0] v, output int lat, output int done_cyc);
        start  = 1'b1;
        bcd_in = v;
        tick();
        start  = 1'b0;
        bcd_in = 12'h5A5;
        lat    = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, overflow, err, bin_out} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b err=%b bin=%h, expected all 0",
                     busy, done, overflow, err, bin_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, dc;
        convert(12'h255, lat, dc);
        n_vec++;
        if (lat !== 12) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 12", lat);
        end
        n_vec++;
        if ({overflow, err, bin_out} !== {1'b0, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL basic_255: got bin=%h ovf=%b err=%b expected bin=ff ovf=0 err=0",
                     bin_out, overflow, err);
        end
        tick();
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_overflow();
        int lat, dc;
        convert(12'h999, lat, dc);
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd12, 1'b1, 1'b0, 8'hE7}) begin
            n_fail++;
            $display("FAIL conv_999: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=e7 ovf=1 err=0",
                     lat, bin_out, overflow, err);
        end
        tick();
        convert(12'h000, lat, dc);
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd12, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL conv_000: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=00 ovf=0 err=0",
                     lat, bin_out, overflow, err);
        end
        tick();
    endtask

    task automatic test_invalid();
        int lat, dc;
        convert(12'h1A3, lat, dc);
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL invalid_1a3: got lat=%0d bin=%h ovf=%b err=%b expected lat=0 bin=00 ovf=0 err=1",
                     lat, bin_out, overflow, err);
        end
        tick();
        convert(12'h128, lat, dc);
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd12, 1'b0, 1'b0, 8'h80}) begin
            n_fail++;
            $display("FAIL after_err_128: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=80 ovf=0 err=0",
                     lat, bin_out, overflow, err);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int lat;
        int pulses;
        start  = 1'b1;
        bcd_in = 12'h042;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start  = 1'b1;
        bcd_in = 12'h999;
        tick();
        start = 1'b0;
        lat   = 4;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd12, 1'b0, 1'b0, 8'h2A}) begin
            n_fail++;
            $display("FAIL ignore_042: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=2a ovf=0 err=0",
                     lat, bin_out, overflow, err);
        end
        start  = 1'b1;
        bcd_in = 12'h999;
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            tick();
        end
        n_vec++;
        if ({pulses[4:0], busy, bin_out} !== {5'd0, 1'b0, 8'h2A}) begin
            n_fail++;
            $display("FAIL ignore_extra_done: got pulses=%0d busy=%b bin=%h expected 0 0 2a",
                     pulses, busy, bin_out);
        end
    endtask

    task automatic test_reset_abort();
        int lat, dc;
        int pulses;
        start  = 1'b1;
        bcd_in = 12'h200;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_shift: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, overflow, err, bin_out} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b ovf=%b err=%b bin=%h, expected all 0",
                     busy, done, overflow, err, bin_out);
        end
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        convert(12'h256, lat, dc);
        n_vec++;
        if ({lat[4:0], overflow, err, bin_out} !== {5'd12, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL conv_256: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=00 ovf=1 err=0",
                     lat, bin_out, overflow, err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, c1, c2;
        convert(12'h001, lat1, c1);
        n_vec++;
        if ({lat1[4:0], overflow, err, bin_out} !== {5'd12, 1'b0, 1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d bin=%h ovf=%b err=%b expected lat=12 bin=01 ovf=0 err=0",
                     lat1, bin_out, overflow, err);
        end
        tick();
        convert(12'h100, lat2, c2);
        n_vec++;
        if ({overflow, err, bin_out} !== {1'b0, 1'b0, 8'h64}) begin
            n_fail++;
            $display("FAIL b2b_second: got bin=%h ovf=%b err=%b expected bin=64 ovf=0 err=0",
                     bin_out, overflow, err);
        end
        n_vec++;
        if ((c2 - c1) !== 14) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected 14", c2 - c1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_invalid();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter. It is the reverse direction of the team's binary-to-BCD path on the 8-bit arithmetic datapath.
- Accepts a packed DIGITS-digit BCD word and produces the unsigned binary value using reverse double-dabble: shift right, then subtract 3 from any digit that is 8 or more.
- Uses a start/busy/done handshake.
- Flags out-of-range results and invalid BCD digits.

Parameters:
- DIGITS, 3, number of BCD digits in the input (input width 4*DIGITS).
- BIN_W, 8, width of the binary result output.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 in bits [3:0].
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; results valid from this cycle.
- bin_out  output  BIN_W  binary result; low BIN_W bits of the full value.
- overflow  output  1  full value exceeds 2^BIN_W-1.
- err  output  1  some input digit was greater than 9.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, shift counter 0, busy 0, done 0, bin_out 0, overflow 0, err 0, internal shift register cleared.
- Reset asserted mid-conversion aborts immediately; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1, capture bcd_in.
  - If any digit is greater than 9: go to DONE with err=1, bin_out=0, overflow=0.
  - Otherwise: load the BCD register, clear the binary accumulator and counter, go to SHIFT.
  - While start=0, stay in IDLE.
- SHIFT, one iteration per clock:
  - Shift {bcd_reg, acc} right by 1.
  - Then, for each digit of the shifted bcd_reg, subtract 3 if the digit is 8 or more.
  - The counter increments each iteration.
  - After 4*DIGITS iterations, go to DONE.
- Accumulator width is 4*DIGITS bits, which is sufficient for 10^DIGITS-1.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Registers update on entry: bin_out = acc[BIN_W-1:0]; overflow = 1 if acc[4*DIGITS-1:BIN_W] is nonzero; err = 0 for a valid input.
  - Next state is IDLE.
- Latency:
  - Valid input: start is accepted on edge 0 and done is high in the cycle after edge 4*DIGITS (12 for the default).
  - Invalid input: done is high in the cycle after edge 0.
- busy is high in SHIFT and DONE.
- start is ignored while busy, including in the DONE cycle; the bench must drop it or re-raise it after done.
- bin_out, overflow and err hold their values until the next DONE entry. They are not cleared when the next conversion is accepted.
- bcd_in may change freely after the accept edge; only the captured copy is used.
- Back-to-back operation: start high on the first IDLE cycle after DONE is accepted normally. Minimum conversion period is 4*DIGITS+2 cycles.
- Wrap rule: bin_out truncates; it does not saturate. This matches the truncating convention of the adder-subtractor.
- If BIN_W is at least 4*DIGITS, overflow is tied to 0.

Test Plan:
- After reset with rst_n low: all outputs 0 and busy 0. Release, then start with bcd_in=12'h255 -> done in the 12th cycle after accept, bin_out=8'hFF, overflow=0, err=0.
- bcd_in=12'h999 -> bin_out=8'hE7 (999 mod 256), overflow=1, err=0. Then bcd_in=12'h000 -> bin_out=8'h00, overflow=0.
- bcd_in=12'h1A3 -> done in the cycle after accept, err=1, bin_out=8'h00, overflow=0. A following 12'h128 -> bin_out=8'h80, err=0.
- Start 12'h042, pulse start again with 12'h999 during SHIFT and during the DONE cycle -> only one done, bin_out=8'h2A. The second request is ignored.
- Start 12'h200, assert rst_n low at iteration 5 -> outputs 0 immediately, no done pulse. After release, 12'h256 -> bin_out=8'h00, overflow=1.
- Back-to-back: 12'h001 then start on the first IDLE cycle after done with 12'h100 -> done pulses exactly 14 cycles apart, bin_out 8'h01 then 8'h64.
